multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, and it generates the 3-bit ALUOp code that the ALU control decoder consumes. It also stalls on a memory ready handshake.

## Interface
Parameters:
- None. Opcode values, ALUOp codes and state encodings live in the shared package.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Opcode  in  6  instr[31:26] from the instruction register; sampled only in DECODE
- MemReady  in  1  memory completion strobe; sampled only in FETCH, MEMRD, MEMWR
- PCWrite  out  1  unconditional PC update
- PCWriteCond  out  1  PC update if ALU Zero
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut
- MemRead, MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  1 = writeback from MDR
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  out  3  111 = R-type (funct decides), 100 = add, 101 = or, 000 = lui, 001 = sub
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode

## Operation
- The state register resets to IDLE. IDLE drives all outputs to 0, including ALUOp = 000, and moves unconditionally to FETCH.
- Opcode is latched into op_q on the DECODE cycle. Every later state uses op_q.
- Outputs not listed for a state are 0. ALUOp defaults to 100.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSrc=00. IRWrite and PCWrite equal MemReady (Mealy). Stay in FETCH while MemReady=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (branch target precompute). Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → REX
  - 001000, 001101 or 001111 → IEX
  - 000100 → BEQ
  - 000010 → JMP
  - anything else → FETCH, with IllegalOp asserted for exactly the next cycle (registered).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=100. Go to MEMRD if op_q is lw, MEMWR if sw.
- MEMRD: MemRead=1, IorD=1. Wait for MemReady, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for MemReady, then go to FETCH.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Then RWB.
- RWB: RegWrite=1, RegDst=1. Then FETCH.
- IEX: ALUSrcA=1, ALUSrcB=10. ALUOp is 100 for addi, 101 for ori, 000 for lui. Then IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSrc=01. Then FETCH.
- JMP: PCWrite=1, PCSrc=10. Then FETCH.
- ALUOp=001 is the sub code. The ALU control decoder must map it to its subtract operation (0100).

## Timing
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, I-type 4, beq 3, j 3. Each MemReady=0 cycle in a wait state adds one cycle.
- Memory handshake: the strobe is held constant until the cycle MemReady=1 is sampled; the FSM leaves that state on the next edge. MemReady is ignored in all other states.
- Exactly one write enable (PCWrite, RegWrite or MemWrite) is asserted per retiring state. MemRead and MemWrite are never both 1.
- Reset asserted in any state, including mid-wait: the next edge goes to IDLE. Outputs, op_q and IllegalOp clear that same edge; no partial writeback completes afterwards.
- An illegal opcode causes no register or memory write. The PC was already incremented in FETCH, so execution resumes at PC+4.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, JMP)
  - opcode constants
  - ALUOp constants shared with the ALU control decoder
  - ALUSrcB and PCSrc encodings
- One sub-module, opcode_class_decode: purely combinational, Opcode to {is_mem, is_r, is_i, is_beq, is_j, illegal}. It is used by the DECODE next-state logic.

## Test plan
- Reset held for 3 cycles, then released with MemReady=1 → all outputs 0 during reset; the cycle after release is IDLE, then FETCH with MemRead=1, IRWrite=1, PCWrite=1.
- lw (100011), MemReady=1 except 2 wait cycles in MEMRD → path FETCH, DECODE, MEMADR, MEMRD×3, MEMWB; total 7 cycles; RegWrite=1 with MemtoReg=1 only in MEMWB.
- R-type (000000) → ALUOp=111 in REX; RWB has RegDst=1, RegWrite=1; 4 cycles.
- ori (001101), then lui (001111) → ALUOp=101 and then 000 in IEX, ALUSrcB=10.
- beq (000100) → ALUOp=001, PCWriteCond=1, PCSrc=01 in the 3rd cycle; j (000010) → PCWrite=1, PCSrc=10.
- Opcode 111111 → IllegalOp high exactly one cycle; no RegWrite or MemWrite; FETCH follows DECODE. Separately: reset asserted mid-MEMWR wait → MemWrite drops at the next edge and the state is IDLE.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared state, opcode, ALUOp and mux-select encodings for the
//               multicycle MIPS control path.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_REX    = 4'd7,
        ST_RWB    = 4'd8,
        ST_IEX    = 4'd9,
        ST_IWB    = 4'd10,
        ST_BEQ    = 4'd11,
        ST_JMP    = 4'd12
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_LUI   = 6'b001111;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    // ALUOp codes consumed by the ALU control decoder (SUB maps to 0100 there)
    localparam logic [2:0] C_ALUOP_RTYPE = 3'b111;
    localparam logic [2:0] C_ALUOP_ADD   = 3'b100;
    localparam logic [2:0] C_ALUOP_OR    = 3'b101;
    localparam logic [2:0] C_ALUOP_LUI   = 3'b000;
    localparam logic [2:0] C_ALUOP_SUB   = 3'b001;

    localparam logic [1:0] C_SRCB_RT      = 2'b00;
    localparam logic [1:0] C_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] C_SRCB_IMM     = 2'b10;
    localparam logic [1:0] C_SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic is_mem;
        logic is_r;
        logic is_i;
        logic is_beq;
        logic is_j;
        logic illegal;
    } opclass_t;

endpackage
`default_nettype wire

// File: rtl/opcode_class_decode.sv
`default_nettype none
// ============================================================================
// Module      : opcode_class_decode
// Description : Combinational opcode classifier used by the DECODE state.
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_class_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output opclass_t   o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            C_OP_LW, C_OP_SW:             o_class.is_mem  = 1'b1;
            C_OP_RTYPE:                   o_class.is_r    = 1'b1;
            C_OP_ADDI, C_OP_ORI, C_OP_LUI: o_class.is_i   = 1'b1;
            C_OP_BEQ:                     o_class.is_beq  = 1'b1;
            C_OP_J:                       o_class.is_j    = 1'b1;
            default:                      o_class.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multicycle MIPS datapath with a
//               MemReady stall handshake and a registered IllegalOp pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic       IllegalOp
);

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_op_q;
    logic       r_illegal;
    opclass_t   w_class;

    opcode_class_decode u_opcode_class_decode (
        .i_opcode (Opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op_q    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_op_q <= Opcode;
            end
            // Pulse lands in the cycle after DECODE and clears on its own
            r_illegal <= (r_state == ST_DECODE) && w_class.illegal;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   w_next_state = ST_FETCH;
            ST_FETCH:  w_next_state = MemReady ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (w_class.is_mem)      w_next_state = ST_MEMADR;
                else if (w_class.is_r)   w_next_state = ST_REX;
                else if (w_class.is_i)   w_next_state = ST_IEX;
                else if (w_class.is_beq) w_next_state = ST_BEQ;
                else if (w_class.is_j)   w_next_state = ST_JMP;
                else                     w_next_state = ST_FETCH;
            end
            ST_MEMADR: w_next_state = (r_op_q == C_OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  w_next_state = MemReady ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  w_next_state = ST_FETCH;
            ST_MEMWR:  w_next_state = MemReady ? ST_FETCH : ST_MEMWR;
            ST_REX:    w_next_state = ST_RWB;
            ST_RWB:    w_next_state = ST_FETCH;
            ST_IEX:    w_next_state = ST_IWB;
            ST_IWB:    w_next_state = ST_FETCH;
            ST_BEQ:    w_next_state = ST_FETCH;
            ST_JMP:    w_next_state = ST_FETCH;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = C_SRCB_RT;
        PCSrc       = C_PCSRC_ALU;
        ALUOp       = C_ALUOP_ADD;
        case (r_state)
            ST_IDLE: ALUOp = C_ALUOP_LUI;
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = C_SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            ST_DECODE: ALUSrcB = C_SRCB_IMM_SH2;
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = C_SRCB_IMM;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_REX: begin
                ALUSrcA = 1'b1;
                ALUOp   = C_ALUOP_RTYPE;
            end
            ST_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = C_SRCB_IMM;
                case (r_op_q)
                    C_OP_ORI: ALUOp = C_ALUOP_OR;
                    C_OP_LUI: ALUOp = C_ALUOP_LUI;
                    default:  ALUOp = C_ALUOP_ADD;
                endcase
            end
            ST_IWB: RegWrite = 1'b1;
            ST_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = C_ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSrc       = C_PCSRC_ALUOUT;
            end
            ST_JMP: begin
                PCWrite = 1'b1;
                PCSrc   = C_PCSRC_JUMP;
            end
            default: ALUOp = C_ALUOP_LUI;
        endcase
    end

    assign IllegalOp = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Scoreboard bench; an instruction-level model queues the
//               expected control vector of every cycle, a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } ov_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOp;
    ov_t        act;

    ov_t   exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    ill_pending = 1'b0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSrc       (PCSrc),
        .ALUOp       (ALUOp),
        .IllegalOp   (IllegalOp)
    );

    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp, IllegalOp};

    // Monitor: one expected vector per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ov_t   e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL %s: got %b required %b", t, act, e);
            n_checks++;
            if (!(act.mrd === 1'b1 && act.mwr === 1'b1)) n_pass++;
            else $display("FAIL %s strobes: got MemRead=1 MemWrite=1 required not both", t);
        end
    end

    function automatic ov_t base();
        ov_t b;
        b       = '0;
        b.aluop = 3'b100;
        return b;
    endfunction

    task automatic cyc(input logic r, input logic [5:0] op, input logic mr,
                       input ov_t e, input string t);
        reset    = r;
        Opcode   = op;
        MemReady = mr;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic fetch(input int waits);
        ov_t e;
        for (int i = 0; i < waits; i++) begin
            e      = base();
            e.mrd  = 1'b1;
            e.srcb = 2'b01;
            e.ill  = (i == 0) && ill_pending;
            cyc(1'b0, rop(), 1'b0, e, "fetch_wait");
        end
        e      = base();
        e.mrd  = 1'b1;
        e.srcb = 2'b01;
        e.irw  = 1'b1;
        e.pcw  = 1'b1;
        e.ill  = (waits == 0) && ill_pending;
        cyc(1'b0, rop(), 1'b1, e, "fetch");
        ill_pending = 1'b0;
    endtask

    // Memory access state: waits with MemReady low, then the completing cycle
    task automatic mem_access(input bit is_write, input int waits);
        ov_t e;
        e      = base();
        e.iord = 1'b1;
        if (is_write) e.mwr = 1'b1;
        else          e.mrd = 1'b1;
        for (int i = 0; i < waits; i++)
            cyc(1'b0, rop(), 1'b0, e, is_write ? "memwr_wait" : "memrd_wait");
        cyc(1'b0, rop(), 1'b1, e, is_write ? "memwr" : "memrd");
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        ov_t e;
        fetch(fw);
        e      = base();
        e.srcb = 2'b11;
        cyc(1'b0, op, rbit(), e, "decode");
        case (op)
            6'b100011, 6'b101011: begin
                e      = base();
                e.srca = 1'b1;
                e.srcb = 2'b10;
                cyc(1'b0, rop(), rbit(), e, "memadr");
                if (op == 6'b100011) begin
                    mem_access(1'b0, mw);
                    e     = base();
                    e.rw  = 1'b1;
                    e.m2r = 1'b1;
                    cyc(1'b0, rop(), rbit(), e, "memwb");
                end else begin
                    mem_access(1'b1, mw);
                end
            end
            6'b000000: begin
                e       = base();
                e.srca  = 1'b1;
                e.aluop = 3'b111;
                cyc(1'b0, rop(), rbit(), e, "rex");
                e      = base();
                e.rw   = 1'b1;
                e.rdst = 1'b1;
                cyc(1'b0, rop(), rbit(), e, "rwb");
            end
            6'b001000, 6'b001101, 6'b001111: begin
                e       = base();
                e.srca  = 1'b1;
                e.srcb  = 2'b10;
                e.aluop = (op == 6'b001101) ? 3'b101 :
                          (op == 6'b001111) ? 3'b000 : 3'b100;
                cyc(1'b0, rop(), rbit(), e, "iex");
                e    = base();
                e.rw = 1'b1;
                cyc(1'b0, rop(), rbit(), e, "iwb");
            end
            6'b000100: begin
                e       = base();
                e.srca  = 1'b1;
                e.aluop = 3'b001;
                e.pcwc  = 1'b1;
                e.pcsrc = 2'b01;
                cyc(1'b0, rop(), rbit(), e, "beq");
            end
            6'b000010: begin
                e       = base();
                e.pcw   = 1'b1;
                e.pcsrc = 2'b10;
                cyc(1'b0, rop(), rbit(), e, "jmp");
            end
            default: ill_pending = 1'b1;
        endcase
    endtask

    logic [5:0] op_tab [9];

    initial begin
        ov_t e;
        op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001101,
                   6'b001111, 6'b000100, 6'b000010, 6'b111111};
        reset    = 1'b1;
        Opcode   = '0;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, rop(), 1'b1, '0, "reset");
        cyc(1'b1, rop(), 1'b1, '0, "reset");
        cyc(1'b0, rop(), 1'b1, '0, "idle");

        run_instr(6'b100011, 0, 2);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b001101, 1, 0);
        run_instr(6'b001111, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b101011, 0, 1);

        // Reset during a MEMWR wait: back to IDLE, no write completes
        fetch(0);
        e      = base();
        e.srcb = 2'b11;
        cyc(1'b0, 6'b101011, 1'b0, e, "decode");
        e      = base();
        e.srca = 1'b1;
        e.srcb = 2'b10;
        cyc(1'b0, rop(), 1'b0, e, "memadr");
        e      = base();
        e.iord = 1'b1;
        e.mwr  = 1'b1;
        cyc(1'b1, rop(), 1'b0, e, "memwr_reset");
        cyc(1'b0, rop(), 1'b0, '0, "idle_after_reset");
        ill_pending = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = op_tab[$urandom_range(0, 8)];
            if (op == 6'b111111) op = rop();
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        fetch(0);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
